// File: rtl/fft_pkg.sv
// Shared FFT front-end types and default geometry (9-bit samples, 16 lanes, 16-beat half-frame).
package fft_pkg;
  localparam int FFT_WIDTH    = 9;
  localparam int FFT_LANES    = 16;
  localparam int FFT_HALF_CYC = 16;

  typedef logic signed [FFT_WIDTH-1:0] sample_t;

  typedef enum logic [1:0] {IDLE, FILL, PAIR} ibuf_state_e;
endpackage

// File: rtl/bf2i_input_buffer_if.sv
// Sample stream into the input buffer and the paired stream out toward BF2I.
interface bf2i_input_buffer_if
  import fft_pkg::*;
#(
  parameter int WIDTH = FFT_WIDTH,
  parameter int LANES = FFT_LANES
);
  logic                        din_valid;
  logic                        din_sof;
  logic [LANES-1:0][WIDTH-1:0] din_re;
  logic [LANES-1:0][WIDTH-1:0] din_im;
  logic [LANES-1:0][WIDTH-1:0] dout_R1;
  logic [LANES-1:0][WIDTH-1:0] dout_R2;
  logic [LANES-1:0][WIDTH-1:0] dout_Q1;
  logic [LANES-1:0][WIDTH-1:0] dout_Q2;
  logic                        en;
  logic                        dout_sof;
  logic                        frame_err;

  modport master (
    output din_valid, din_sof, din_re, din_im,
    input  dout_R1, dout_R2, dout_Q1, dout_Q2, en, dout_sof, frame_err
  );

  modport slave (
    input  din_valid, din_sof, din_re, din_im,
    output dout_R1, dout_R2, dout_Q1, dout_Q2, en, dout_sof, frame_err
  );
endinterface

// File: rtl/bf2i_input_buffer_half_mem.sv
// Half-frame store: synchronous write, combinational read, no reset (macro-replaceable).
module bf2i_half_mem #(
  parameter int DEPTH = 16,
  parameter int DW    = 288
) (
  input  logic                     clk,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_waddr,
  input  logic [DW-1:0]            i_wdata,
  input  logic [$clog2(DEPTH)-1:0] i_raddr,
  output logic [DW-1:0]            o_rdata
);
  logic [DW-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/bf2i_input_buffer.sv
// Stores the first half-frame, then pairs each stored beat with the live second-half beat for BF2I.
module bf2i_input_buffer
  import fft_pkg::*;
#(
  parameter int WIDTH    = FFT_WIDTH,
  parameter int LANES    = FFT_LANES,
  parameter int HALF_CYC = FFT_HALF_CYC
) (
  input logic                clk,
  input logic                rst_n,
  bf2i_input_buffer_if.slave bus
);
  localparam int CW = $clog2(2*HALF_CYC);
  localparam int AW = $clog2(HALF_CYC);
  localparam int DW = 2*WIDTH*LANES;

  ibuf_state_e                 r_state;
  logic [CW-1:0]               r_cnt;
  logic [LANES-1:0][WIDTH-1:0] r_R1, r_R2, r_Q1, r_Q2;
  logic                        r_en, r_sof, r_err;

  logic                        w_we;
  logic [AW-1:0]               w_waddr;
  logic [DW-1:0]               w_rdata;
  logic [LANES-1:0][WIDTH-1:0] w_st_re, w_st_im;

  // An sof always lands in slot 0, whatever state it interrupts.
  always_comb begin
    w_we    = bus.din_valid & (bus.din_sof | (r_state == FILL));
    w_waddr = bus.din_sof ? '0 : r_cnt[AW-1:0];
  end

  // HALF_CYC is a power of 2, so cnt-HALF_CYC in PAIR is just the low bits.
  bf2i_half_mem #(.DEPTH(HALF_CYC), .DW(DW)) u_mem (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata ({bus.din_im, bus.din_re}),
    .i_raddr (r_cnt[AW-1:0]),
    .o_rdata (w_rdata)
  );

  assign {w_st_im, w_st_re} = w_rdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_R1    <= '0;
      r_R2    <= '0;
      r_Q1    <= '0;
      r_Q2    <= '0;
      r_en    <= 1'b0;
      r_sof   <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_R1  <= '0;
      r_R2  <= '0;
      r_Q1  <= '0;
      r_Q2  <= '0;
      r_en  <= 1'b0;
      r_sof <= 1'b0;
      r_err <= 1'b0;
      if (bus.din_valid) begin
        if (bus.din_sof) begin
          r_err   <= (r_state != IDLE);
          r_cnt   <= CW'(1);
          r_state <= FILL;
        end else begin
          case (r_state)
            IDLE: r_err <= 1'b1;
            FILL: begin
              r_cnt <= r_cnt + 1'b1;
              if (r_cnt == CW'(HALF_CYC-1)) r_state <= PAIR;
            end
            PAIR: begin
              r_R1  <= w_st_re;
              r_Q1  <= w_st_im;
              r_R2  <= bus.din_re;
              r_Q2  <= bus.din_im;
              r_en  <= 1'b1;
              r_sof <= (r_cnt == CW'(HALF_CYC));
              if (r_cnt == CW'(2*HALF_CYC-1)) begin
                r_cnt   <= '0;
                r_state <= IDLE;
              end else begin
                r_cnt <= r_cnt + 1'b1;
              end
            end
            default: r_state <= IDLE;
          endcase
        end
      end
    end
  end

  assign bus.dout_R1   = r_R1;
  assign bus.dout_R2   = r_R2;
  assign bus.dout_Q1   = r_Q1;
  assign bus.dout_Q2   = r_Q2;
  assign bus.en        = r_en;
  assign bus.dout_sof  = r_sof;
  assign bus.frame_err = r_err;
endmodule

// File: tb/tb_bf2i_input_buffer.sv
// Scoreboard bench: driver pushes expected pairs, monitor pops on en and checks idle-zero outputs.
module tb_bf2i_input_buffer;
  import fft_pkg::*;

  typedef logic [FFT_LANES-1:0][FFT_WIDTH-1:0] beat_t;
  typedef struct {
    beat_t r1, r2, q1, q2;
    logic  sof;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bf2i_input_buffer_if #(.WIDTH(FFT_WIDTH), .LANES(FFT_LANES)) bus ();

  bf2i_input_buffer #(.WIDTH(FFT_WIDTH), .LANES(FFT_LANES), .HALF_CYC(FFT_HALF_CYC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  int   err_seen = 0;

  // pattern 0: ramp (beat*16+lane)%256 on both parts; pattern 1: cycles through -1/-256/255
  function automatic sample_t val(int pat, int comp, int b, int i);
    int s;
    if (pat == 0) return sample_t'((b*16 + i) % 256);
    s = (comp == 0) ? (b + i) % 3 : (b + 2*i + 1) % 3;
    case (s)
      0:       return sample_t'(-1);
      1:       return sample_t'(-256);
      default: return sample_t'(255);
    endcase
  endfunction

  function automatic beat_t mk(int pat, int comp, int b);
    beat_t v;
    for (int i = 0; i < FFT_LANES; i++) v[i] = val(pat, comp, b, i);
    return v;
  endfunction

  task automatic chk(string name, int act, int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic drive(bit v, bit s, int pat, int b);
    @(negedge clk);
    bus.din_valid = v;
    bus.din_sof   = s;
    bus.din_re    = v ? mk(pat, 0, b) : '0;
    bus.din_im    = v ? mk(pat, 1, b) : '0;
  endtask

  task automatic gap();
    drive(1'b0, 1'b0, 0, 0);
  endtask

  task automatic send_frame(int pat, bit gappy, int nbeats);
    exp_t e;
    for (int b = 0; b < nbeats; b++) begin
      if (gappy && b > 0) gap();
      if (b >= 16) begin
        e.r1  = mk(pat, 0, b - 16);
        e.r2  = mk(pat, 0, b);
        e.q1  = mk(pat, 1, b - 16);
        e.q2  = mk(pat, 1, b);
        e.sof = (b == 16);
        q.push_back(e);
      end
      drive(1'b1, b == 0, pat, b);
    end
  endtask

  task automatic finish_test(string name, int err_base, int err_req);
    repeat (4) gap();
    chk({name, "_drain"}, q.size(), 0);
    chk({name, "_frame_err"}, err_seen - err_base, err_req);
    q.delete();
  endtask

  // Monitor: pop on every en, otherwise outputs must be zero.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (bus.frame_err) err_seen++;
    checks++;
    if (bus.en) begin
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_en: got en=1 sof=%0b, expected en=0", bus.dout_sof);
      end else begin
        e = q.pop_front();
        if (bus.dout_R1 !== e.r1 || bus.dout_R2 !== e.r2 || bus.dout_Q1 !== e.q1 ||
            bus.dout_Q2 !== e.q2 || bus.dout_sof !== e.sof) begin
          errors++;
          $display("FAIL pair: got R1=%h R2=%h sof=%0b, expected R1=%h R2=%h sof=%0b (Q1 %h/%h Q2 %h/%h)",
                   bus.dout_R1, bus.dout_R2, bus.dout_sof, e.r1, e.r2, e.sof,
                   bus.dout_Q1, e.q1, bus.dout_Q2, e.q2);
        end
      end
    end else if (bus.dout_R1 != '0 || bus.dout_R2 != '0 || bus.dout_Q1 != '0 ||
                 bus.dout_Q2 != '0 || bus.dout_sof != 1'b0) begin
      errors++;
      $display("FAIL idle_zero: got nonzero outputs with en=0 (R1=%h), expected all 0", bus.dout_R1);
    end
  end

  initial begin
    int base;
    bus.din_valid = 1'b0;
    bus.din_sof   = 1'b0;
    bus.din_re    = '0;
    bus.din_im    = '0;
    repeat (2) @(negedge clk);
    chk("reset_en", int'(bus.en), 0);
    chk("reset_err", int'(bus.frame_err), 0);
    rst_n = 1'b1;

    // 1: contiguous ramp frame
    base = err_seen;
    send_frame(0, 1'b0, 32);
    finish_test("t1_ramp", base, 0);

    // 2: same frame with a gap after every beat
    base = err_seen;
    send_frame(0, 1'b1, 32);
    finish_test("t2_gappy", base, 0);

    // 3: back-to-back frames, second with extreme values
    base = err_seen;
    send_frame(0, 1'b0, 32);
    send_frame(1, 1'b0, 32);
    finish_test("t3_b2b", base, 0);

    // 4: abort after 10 beats
    base = err_seen;
    send_frame(1, 1'b0, 10);
    send_frame(0, 1'b0, 32);
    finish_test("t4_abort", base, 1);

    // 5: missing sof in IDLE, then a good frame
    base = err_seen;
    for (int b = 0; b < 5; b++) drive(1'b1, 1'b0, 0, b);
    send_frame(1, 1'b0, 32);
    finish_test("t5_nosof", base, 5);

    // 6: reset while beat 24 (k=8) is on the inputs
    base = err_seen;
    send_frame(0, 1'b0, 24);
    drive(1'b1, 1'b0, 0, 24);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_reset_en", int'(bus.en), 0);
    chk("t6_reset_R1_zero", int'(bus.dout_R1 == '0 && bus.dout_R2 == '0), 1);
    chk("t6_flushed", q.size(), 0);
    gap();
    rst_n = 1'b1;
    send_frame(1, 1'b0, 32);
    finish_test("t6_reset", base, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
